// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int unsigned DEF_AW = 8;
  localparam int unsigned DEF_DW = 8;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// load/store path and the debug/loader port; one request/ack per access.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam int unsigned CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dbg_ack_q, dbg_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
  logic          busy_q, busy_d;
  logic          win;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    busy_d      = busy_q;
    // On a tie the port not granted last wins; ptr holds the last grant.
    win         = (cpu_req && dbg_req) ? ~ptr_q : dbg_req;

    unique case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          state_d     = ISSUE;
          owner_d     = win;
          ptr_d       = win;
          we_d        = win ? dbg_we : cpu_we;
          mem_en_d    = 1'b1;
          mem_we_d    = win ? dbg_we : cpu_we;
          mem_addr_d  = win ? dbg_addr : cpu_addr;
          mem_wdata_d = win ? dbg_wdata : cpu_wdata;
          busy_d      = 1'b1;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d   = RESP;
          cpu_ack_d = (owner_q == OWN_CPU);
          dbg_ack_d = (owner_q == OWN_DBG);
        end else begin
          state_d = WAIT;
          cnt_d   = CW'(READ_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d   = RESP;
          cpu_ack_d = (owner_q == OWN_CPU);
          dbg_ack_d = (owner_q == OWN_DBG);
          if (owner_q == OWN_CPU) cpu_rdata_d = mem_rdata;
          else                    dbg_rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= OWN_DBG;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: instance 0 at READ_LAT=1, instance 1 at READ_LAT=3.
module tb_dmem_arbiter;

  logic clk;
  logic rst_n;
  logic [1:0]      cpu_req, cpu_we, cpu_ack, dbg_req, dbg_we, dbg_ack;
  logic [1:0]      mem_en, mem_we, busy, owner;
  logic [1:0][7:0] cpu_addr, cpu_wdata, cpu_rdata, dbg_addr, dbg_wdata, dbg_rdata;
  logic [1:0][7:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {bit port; bit rd; logic [7:0] rdata; int cyc;} ack_t;
  typedef struct {bit we; logic [7:0] addr; logic [7:0] wdata; int cyc;} men_t;

  ack_t ackq[2][$];
  men_t menq[2][$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(bit ok, string name, int act, int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endfunction

  function automatic int lat(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic bit outs_zero(int i);
    return !(mem_en[i] | mem_we[i] | (|mem_addr[i]) | (|mem_wdata[i]) | cpu_ack[i] |
             dbg_ack[i] | (|cpu_rdata[i]) | (|dbg_rdata[i]) | busy[i] | owner[i]);
  endfunction

  function automatic void mon(int i);
    men_t m;
    ack_t a;
    if (mem_en[i]) begin
      if (menq[i].size() == 0) chk(0, $sformatf("inst%0d unexpected mem_en", i), 1, 0);
      else begin
        m = menq[i].pop_front();
        chk(cyc == m.cyc, $sformatf("inst%0d mem_en cycle", i), cyc, m.cyc);
        chk(mem_we[i] == m.we, $sformatf("inst%0d mem_we", i), int'(mem_we[i]), int'(m.we));
        chk(mem_addr[i] == m.addr, $sformatf("inst%0d mem_addr", i), int'(mem_addr[i]), int'(m.addr));
        if (m.we)
          chk(mem_wdata[i] == m.wdata, $sformatf("inst%0d mem_wdata", i), int'(mem_wdata[i]), int'(m.wdata));
        chk(busy[i] == 1'b1, $sformatf("inst%0d busy at issue", i), int'(busy[i]), 1);
      end
    end
    if (cpu_ack[i] && dbg_ack[i]) chk(0, $sformatf("inst%0d ack overlap", i), 3, 1);
    if (cpu_ack[i] || dbg_ack[i]) begin
      if (ackq[i].size() == 0) chk(0, $sformatf("inst%0d unexpected ack", i), 1, 0);
      else begin
        a = ackq[i].pop_front();
        chk(dbg_ack[i] == a.port, $sformatf("inst%0d ack port", i), int'(dbg_ack[i]), int'(a.port));
        chk(cyc == a.cyc, $sformatf("inst%0d ack cycle", i), cyc, a.cyc);
        chk(owner[i] == a.port, $sformatf("inst%0d owner", i), int'(owner[i]), int'(a.port));
        if (a.rd) begin
          if (a.port) chk(dbg_rdata[i] == a.rdata, $sformatf("inst%0d dbg_rdata", i),
                          int'(dbg_rdata[i]), int'(a.rdata));
          else        chk(cpu_rdata[i] == a.rdata, $sformatf("inst%0d cpu_rdata", i),
                          int'(cpu_rdata[i]), int'(a.rdata));
        end
      end
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned L = (g == 0) ? 1 : 3;
    logic [7:0] mem [256];
    logic [7:0] pipe [3];

    dmem_arbiter #(.AW(8), .DW(8), .READ_LAT(L)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_req   (cpu_req[g]),
      .cpu_we    (cpu_we[g]),
      .cpu_addr  (cpu_addr[g]),
      .cpu_wdata (cpu_wdata[g]),
      .cpu_ack   (cpu_ack[g]),
      .cpu_rdata (cpu_rdata[g]),
      .dbg_req   (dbg_req[g]),
      .dbg_we    (dbg_we[g]),
      .dbg_addr  (dbg_addr[g]),
      .dbg_wdata (dbg_wdata[g]),
      .dbg_ack   (dbg_ack[g]),
      .dbg_rdata (dbg_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g]),
      .owner     (owner[g])
    );

    // Memory model: read data is valid exactly L cycles after mem_en, junk otherwise.
    always @(posedge clk) begin
      pipe[0] <= mem_en[g] ? mem[mem_addr[g]] : 8'hEE;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      if (mem_en[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
    end
    assign mem_rdata[g] = pipe[L-1];

    always @(negedge clk) mon(g);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int i, bit port, bit we, logic [7:0] a, logic [7:0] d);
    if (port) begin
      dbg_we[i] = we; dbg_addr[i] = a; dbg_wdata[i] = d; dbg_req[i] = 1'b1;
    end else begin
      cpu_we[i] = we; cpu_addr[i] = a; cpu_wdata[i] = d; cpu_req[i] = 1'b1;
    end
  endtask

  task automatic push_men(int i, bit we, logic [7:0] a, logic [7:0] d, int c);
    menq[i].push_back('{we, a, d, c});
  endtask

  task automatic push_ack(int i, bit port, bit rd, logic [7:0] rdata, int c);
    ackq[i].push_back('{port, rd, rdata, c});
  endtask

  // Request issued to an idle arbiter in the current cycle.
  task automatic start(int i, bit port, bit we, logic [7:0] a, logic [7:0] d, logic [7:0] exp_rd);
    int c = cyc;
    drive(i, port, we, a, d);
    push_men(i, we, a, d, c + 1);
    push_ack(i, port, !we, exp_rd, we ? c + 2 : c + 2 + lat(i));
  endtask

  task automatic wait_ack(int i, bit port);
    bit got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = port ? dbg_ack[i] : cpu_ack[i];
    end
    @(posedge clk);
    #1;
    chk(got, $sformatf("inst%0d ack arrival port%0d", i, port), int'(got), 1);
  endtask

  task automatic xact(int i, bit port, bit we, logic [7:0] a, logic [7:0] d, logic [7:0] exp_rd);
    start(i, port, we, a, d, exp_rd);
    wait_ack(i, port);
    if (port) dbg_req[i] = 1'b0;
    else      cpu_req[i] = 1'b0;
  endtask

  // Both ports held; each drops its request after its n-th ack.
  task automatic run_dual(int i, int ncpu, int ndbg);
    int nc = 0;
    int nd = 0;
    bit dc, dd;
    for (int k = 0; k < 60 && (cpu_req[i] || dbg_req[i]); k++) begin
      @(negedge clk);
      dc = cpu_ack[i];
      dd = dbg_ack[i];
      @(posedge clk);
      #1;
      if (dc) begin nc++; if (nc == ncpu) cpu_req[i] = 1'b0; end
      if (dd) begin nd++; if (nd == ndbg) dbg_req[i] = 1'b0; end
    end
    chk(!cpu_req[i] && !dbg_req[i], $sformatf("inst%0d dual completion", i),
        int'({cpu_req[i], dbg_req[i]}), 0);
    cpu_req[i] = 1'b0;
    dbg_req[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int c;
    rst_n = 1'b0;
    cpu_req = '0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = '0; dbg_we = '0; dbg_addr = '0; dbg_wdata = '0;
    repeat (3) tick();
    chk(outs_zero(0), "inst0 reset outputs", 1, 0);
    chk(outs_zero(1), "inst1 reset outputs", 1, 0);
    rst_n = 1'b1;

    // CPU write then debug read-back of the same location.
    xact(0, 1'b0, 1'b1, 8'h10, 8'hA5, 8'h00);
    xact(0, 1'b1, 1'b0, 8'h10, 8'h00, 8'hA5);
    chk(cpu_rdata[0] == 8'h00, "inst0 cpu_rdata untouched", int'(cpu_rdata[0]), 0);

    // Contended reads: cpu, dbg, cpu, dbg at 4 cycles each.
    xact(0, 1'b0, 1'b1, 8'h01, 8'h11, 8'h00);
    xact(0, 1'b1, 1'b1, 8'h02, 8'h22, 8'h00);
    drive(0, 1'b0, 1'b0, 8'h01, 8'h00);
    drive(0, 1'b1, 1'b0, 8'h02, 8'h00);
    c = cyc;
    push_men(0, 1'b0, 8'h01, 8'h00, c + 1);  push_ack(0, 1'b0, 1'b1, 8'h11, c + 3);
    push_men(0, 1'b0, 8'h02, 8'h00, c + 5);  push_ack(0, 1'b1, 1'b1, 8'h22, c + 7);
    push_men(0, 1'b0, 8'h01, 8'h00, c + 9);  push_ack(0, 1'b0, 1'b1, 8'h11, c + 11);
    push_men(0, 1'b0, 8'h02, 8'h00, c + 13); push_ack(0, 1'b1, 1'b1, 8'h22, c + 15);
    run_dual(0, 2, 2);

    // Long read latency on instance 1.
    xact(1, 1'b0, 1'b1, 8'h20, 8'h5C, 8'h00);
    xact(1, 1'b0, 1'b0, 8'h20, 8'h00, 8'h5C);

    // One-cycle dbg pulse while cpu owns the bus must be ignored.
    start(0, 1'b0, 1'b1, 8'h50, 8'h77, 8'h00);
    tick();
    drive(0, 1'b1, 1'b1, 8'h55, 8'h99);
    tick();
    dbg_req[0] = 1'b0;
    wait_ack(0, 1'b0);
    cpu_req[0] = 1'b0;

    // Reset during WAIT of a cpu read: no ack, pointer back to dbg.
    drive(0, 1'b0, 1'b0, 8'h01, 8'h00);
    push_men(0, 1'b0, 8'h01, 8'h00, cyc + 1);
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    chk(outs_zero(0), "inst0 async reset outputs", 1, 0);
    chk(outs_zero(1), "inst1 async reset outputs", 1, 0);
    cpu_req[0] = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    drive(0, 1'b0, 1'b1, 8'h30, 8'h33);
    drive(0, 1'b1, 1'b1, 8'h31, 8'h44);
    c = cyc;
    push_men(0, 1'b1, 8'h30, 8'h33, c + 1); push_ack(0, 1'b0, 1'b0, 8'h00, c + 2);
    push_men(0, 1'b1, 8'h31, 8'h44, c + 4); push_ack(0, 1'b1, 1'b0, 8'h00, c + 5);
    run_dual(0, 1, 1);

    // Back-to-back cpu writes with req held, new fields at each ack edge.
    for (int k = 0; k < 3; k++) begin
      start(0, 1'b0, 1'b1, 8'(8'h40 + k), 8'(8'hA0 + k), 8'h00);
      wait_ack(0, 1'b0);
    end
    cpu_req[0] = 1'b0;
    xact(0, 1'b1, 1'b0, 8'h41, 8'h00, 8'hA1);

    repeat (4) tick();
    for (int i = 0; i < 2; i++) begin
      chk(ackq[i].size() == 0, $sformatf("inst%0d pending acks", i), ackq[i].size(), 0);
      chk(menq[i].size() == 0, $sformatf("inst%0d pending mem_en", i), menq[i].size(), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
